pulse_event_scheduler: RTL

- Detects one-cycle pulses (0-1-0) on each of N independent input lines and counts pending events per channel.
- A round-robin arbiter grants one pending event at a time to a single shared downstream consumer over a valid/ready handshake.
- Sits between raw strobe inputs and a consumer that can service only one event per handshake.

---
 rtl/pulse_event_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pulse_event_scheduler.sv
// Per-channel 0-1-0 pulse detector with pending-event counters and a round-robin
// arbiter feeding one valid/ready consumer. Define PULSE_SCHED_OVERFLOW_EN for sticky overflow flags.
module pulse_event_scheduler #(
  parameter int N     = 4,
  parameter int CNT_W = 4,
  parameter int ID_W  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    a,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  input  logic            out_ready,
  output logic            busy
`ifdef PULSE_SCHED_OVERFLOW_EN
  ,
  output logic [N-1:0]    overflow
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [ID_W-1:0]  ID_ZERO  = {ID_W{1'b0}};
  localparam logic [ID_W-1:0]  ID_ONE   = ID_W'(1'b1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N - 1);

  logic [N-1:0]     r_a;
  logic [N-1:0]     r_a2;
  logic [CNT_W-1:0] r_cnt [N];
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_out_id;
  logic             r_out_valid;

  logic [N-1:0]     w_det;
  logic [N-1:0]     w_elig;
  logic [N-1:0]     w_dec;
  logic             w_slot_free;
  logic             w_found;
  logic             w_found_hi;
  logic             w_load;
  logic [ID_W-1:0]  w_win_hi;
  logic [ID_W-1:0]  w_win_lo;
  logic [ID_W-1:0]  w_winner;
  logic [ID_W-1:0]  w_ptr_nxt;

  assign w_det       = ~r_a2 & r_a & ~a;
  assign w_slot_free = ~r_out_valid | out_ready;
  assign w_found     = |w_elig;
  assign w_load      = w_slot_free & w_found;
  assign w_ptr_nxt   = (w_winner == ID_LAST) ? ID_ZERO : (w_winner + ID_ONE);

  // Eligibility uses registered counts only, so a same-cycle detection is not yet visible
  always_comb begin
    w_elig = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_elig[i] = (r_cnt[i] != CNT_ZERO);
    end
  end

  // Round-robin pick: lowest eligible index at or above r_ptr, else lowest eligible overall
  always_comb begin
    w_win_hi   = r_ptr;
    w_win_lo   = r_ptr;
    w_found_hi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      w_win_hi   = (w_elig[i] && (ID_W'(i) >= r_ptr)) ? ID_W'(i) : w_win_hi;
      w_found_hi = w_found_hi | (w_elig[i] && (ID_W'(i) >= r_ptr));
      w_win_lo   = w_elig[i] ? ID_W'(i) : w_win_lo;
    end
    w_winner = w_found_hi ? w_win_hi : w_win_lo;
  end

  // Per-channel decrement strobe for the channel being loaded into the output register
  always_comb begin
    w_dec = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_dec[i] = w_load && (w_winner == ID_W'(i));
    end
  end

  // Input history, output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a         <= {N{1'b0}};
      r_a2        <= {N{1'b0}};
      r_out_valid <= 1'b0;
      r_out_id    <= ID_ZERO;
      r_ptr       <= ID_ZERO;
    end else begin
      r_a  <= a;
      r_a2 <= r_a;
      if (w_slot_free) begin
        r_out_valid <= w_found;
        if (w_found) begin
          r_out_id <= w_winner;
          r_ptr    <= w_ptr_nxt;
        end
      end
    end
  end

  // Pending counters; a detection at saturation without a decrement is dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        case ({w_det[i], w_dec[i]})
          2'b10:   r_cnt[i] <= (r_cnt[i] == CNT_MAX) ? r_cnt[i] : (r_cnt[i] + CNT_ONE);
          2'b01:   r_cnt[i] <= r_cnt[i] - CNT_ONE;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

`ifdef PULSE_SCHED_OVERFLOW_EN
  logic [N-1:0] r_overflow;

  // Sticky flag recording any dropped event, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow <= {N{1'b0}};
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_det[i] && !w_dec[i] && (r_cnt[i] == CNT_MAX)) begin
          r_overflow[i] <= 1'b1;
        end
      end
    end
  end

  assign overflow = r_overflow;
`endif

  assign out_valid = r_out_valid;
  assign out_id    = r_out_id;
  assign busy      = w_found | r_out_valid;

endmodule
